gs_butterfly_unit: RTL

//  Gentleman-Sande inverse butterfly for the Kyber INTT datapath:
//  (a,b,w) -> (a+b mod q, (a-b)*w mod q).
//  It is the inverse counterpart of the forward Cooley-Tukey butterfly
//  (a+b*w, a-b*w) used in the NTT.

---
 rtl/gs_butterfly_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/gs_butterfly_unit.sv
// Gentleman-Sande inverse butterfly for the Kyber INTT: (a,b,w) -> (a+b mod q, (a-b)*w mod q).
// Latency: 5 enabled cycles, one pair accepted per enabled cycle.
// Backpressure: none beyond enable; enable=0 freezes every stage including valid.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   enable              pipeline advance
//   valid_in, a_in, b_in, twiddle   input pair and inverse twiddle, all < MODULUS
//   valid_out, a_out, b_out         results; data held while valid_out=0
//
// Build option: define GS_HALVE_EN to fold the per-layer INTT 1/2 scaling
// into stage 5 (both results multiplied by 2^-1 mod q). Latency is unchanged.

module gs_butterfly_unit #(
    parameter int DATA_WIDTH = 12,
    parameter int MODULUS    = 3329
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [DATA_WIDTH-1:0] twiddle,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  valid_out
);

    localparam int XW = DATA_WIDTH + 1;       // one guard bit for sums / differences
    localparam int TW = 2 * DATA_WIDTH;       // full product width
    localparam int MW = DATA_WIDTH + 2;       // Barrett constant width

    localparam logic [XW-1:0] QX    = XW'(MODULUS);
    localparam logic [TW-1:0] QT    = TW'(MODULUS);
    localparam logic [MW-1:0] BAR_M = MW'((64'd1 << TW) / MODULUS);

    // stage 1: registered inputs
    logic                  v1;
    logic [DATA_WIDTH-1:0] a1, b1, w1;
    // stage 2: reduced sum and difference
    logic                  v2;
    logic [DATA_WIDTH-1:0] s2, d2, w2;
    // stage 3: raw product
    logic                  v3;
    logic [DATA_WIDTH-1:0] s3;
    logic [TW-1:0]         t3;
    // stage 4: Barrett quotient estimate
    logic                  v4;
    logic [DATA_WIDTH-1:0] s4;
    logic [TW-1:0]         t4;
    logic [XW-1:0]         qe4;

    // ---------------- combinational stage logic ----------------
    logic [XW-1:0]         sum_c, diff_c;
    logic [DATA_WIDTH-1:0] s_c, d_c;
    logic [TW+MW-1:0]      bar_prod_c;
    logic [XW-1:0]         qe_c;
    logic [TW-1:0]         qq_c;
    logic [XW-1:0]         r_c;
    logic [DATA_WIDTH-1:0] b_red_c;
    logic [DATA_WIDTH-1:0] a_fin_c, b_fin_c;

`ifdef GS_HALVE_EN
    // x/2 mod q: odd values borrow one q so the shift is exact.
    function automatic logic [DATA_WIDTH-1:0] halve_mod(input logic [DATA_WIDTH-1:0] x);
        logic [XW-1:0] e;
        e = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
        return DATA_WIDTH'(e >> 1);
    endfunction
`endif

    always_comb begin
        sum_c   = {1'b0, a1} + {1'b0, b1};
        s_c     = DATA_WIDTH'((sum_c >= QX) ? (sum_c - QX) : sum_c);
        // two's-complement difference; the guard bit is the sign, adding q
        // back wraps modulo 2^XW into [0,q)
        diff_c  = {1'b0, a1} - {1'b0, b1};
        d_c     = DATA_WIDTH'(diff_c[XW-1] ? (diff_c + QX) : diff_c);

        // qe <= floor(t/q) and is at most one short, so r lands in [0,2q)
        bar_prod_c = {{MW{1'b0}}, t3} * {{TW{1'b0}}, BAR_M};
        qe_c       = XW'(bar_prod_c >> TW);

        qq_c    = {{(TW-XW){1'b0}}, qe4} * QT;
        r_c     = XW'(t4 - qq_c);
        b_red_c = DATA_WIDTH'((r_c >= QX) ? (r_c - QX) : r_c);

`ifdef GS_HALVE_EN
        a_fin_c = halve_mod(s4);
        b_fin_c = halve_mod(b_red_c);
`else
        a_fin_c = s4;
        b_fin_c = b_red_c;
`endif
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            w1        <= '0;
            v2        <= 1'b0;
            s2        <= '0;
            d2        <= '0;
            w2        <= '0;
            v3        <= 1'b0;
            s3        <= '0;
            t3        <= '0;
            v4        <= 1'b0;
            s4        <= '0;
            t4        <= '0;
            qe4       <= '0;
            valid_out <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
        end else if (enable) begin
            v1  <= valid_in;
            a1  <= a_in;
            b1  <= b_in;
            w1  <= twiddle;

            v2  <= v1;
            s2  <= s_c;
            d2  <= d_c;
            w2  <= w1;

            v3  <= v2;
            s3  <= s2;
            t3  <= {{DATA_WIDTH{1'b0}}, d2} * {{DATA_WIDTH{1'b0}}, w2};

            v4  <= v3;
            s4  <= s3;
            t4  <= t3;
            qe4 <= qe_c;

            valid_out <= v4;
            // output data only moves with a valid item, so it holds across bubbles
            if (v4) begin
                a_out <= a_fin_c;
                b_out <= b_fin_c;
            end
        end
    end

endmodule
